// File: rtl/rr_arbiter16_pkg.sv
// arb_pkg: shared types, sizes and the rotating winner search for rr_arbiter16
package arb_pkg;
  localparam int N_REQ = 16;
  localparam int IDX_W = 4;
  typedef enum logic {IDLE, GRANT} state_t;
  // Rotate so ptr lands at bit 0, take the lowest set bit, then undo the rotation
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req, input logic [IDX_W-1:0] ptr);
    logic [2*N_REQ-1:0] dbl;
    logic [IDX_W:0] r;
    dbl = {req, req} >> ptr;
    r = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (dbl[i]) r = {1'b1, IDX_W'(i) + ptr};
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter16_if.sv
// rr_arbiter16_if: request/grant bundle between requesting engines and the arbiter
interface rr_arbiter16_if;
  import arb_pkg::*;
  logic en;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic gnt_valid;
  logic preempt;
  modport master (output en, req, input gnt, gnt_idx, gnt_valid, preempt);
  modport slave (input en, req, output gnt, gnt_idx, gnt_valid, preempt);
endinterface

// File: rtl/rr_arbiter16_onehot_dec4to16.sv
// onehot_dec4to16: combinational 4-to-16 one-hot decoder with enable
module onehot_dec4to16 (
  input  logic [3:0]  in,
  input  logic        en,
  output logic [15:0] out
);
  assign out = en ? 16'd1 << in : 16'd0;
endmodule

// File: rtl/rr_arbiter16.sv
// rr_arbiter16: round-robin arbiter for 16 requesters with hold-time preemption
module rr_arbiter16
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 255,
  parameter int CNT_W    = 8
) (
  input logic          clk,
  input logic          rst,
  rr_arbiter16_if.slave bus
);
  state_t state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, idx_q, idx_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic valid_q, valid_d, preempt_q, preempt_d;
  logic [IDX_W:0] pick;
  assign pick = rr_pick(bus.req, ptr_q);
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = '0;
    hold_d    = '0;
    preempt_d = 1'b0;
    if (state_q == IDLE) begin
      if (bus.en && pick[IDX_W]) begin
        state_d = GRANT;
        idx_d   = pick[IDX_W-1:0];
        hold_d  = CNT_W'(1);
      end
    end else if (!bus.en) begin
      state_d = IDLE;
    end else if (!bus.req[idx_q] || hold_q == CNT_W'(MAX_HOLD)) begin
      state_d   = IDLE;
      ptr_d     = idx_q + IDX_W'(1);
      preempt_d = bus.req[idx_q];
    end else begin
      idx_d  = idx_q;
      hold_d = hold_q + CNT_W'(1);
    end
    valid_d = state_d == GRANT;
  end
  onehot_dec4to16 u_dec (.in(idx_d), .en(valid_d), .out(gnt_d));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
    end
  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.preempt   = preempt_q;
endmodule

// File: tb/tb_rr_arbiter16.sv
// tb_rr_arbiter16: directed checks of grant order, bubbles, timeout and resets
module tb_rr_arbiter16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int exp_order [6] = '{0, 1, 15, 0, 1, 15};
  rr_arbiter16_if bus ();
  rr_arbiter16 #(.MAX_HOLD(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    logic [15:0] inv;
    @(posedge clk);
    #1;
    inv = bus.gnt_valid ? 16'd1 << bus.gnt_idx : 16'd0;
    chk("invariant", {16'd0, bus.gnt}, {16'd0, inv});
  endtask
  task automatic chk_gnt(input string tag, input int idx);
    chk({tag, "_gnt"}, {16'd0, bus.gnt}, 32'd1 << idx);
    chk({tag, "_idx"}, {28'd0, bus.gnt_idx}, 32'(idx));
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"}, {16'd0, bus.gnt}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.gnt_valid}, 32'd0);
  endtask
  initial begin
    bus.en = 1'b1;
    bus.req = 16'hFFFF;
    #3;
    chk_idle("t1_async");
    step();
    step();
    chk_idle("t1_reset");
    chk("t1_idx", {28'd0, bus.gnt_idx}, 32'd0);
    chk("t1_preempt", {31'd0, bus.preempt}, 32'd0);
    rst = 1'b0;
    bus.req = 16'h0000;
    step();
    chk_idle("t1_after");
    bus.req = 16'h0020;
    step();
    chk_gnt("t2_grant", 5);
    chk("t2_valid", {31'd0, bus.gnt_valid}, 32'd1);
    bus.req = 16'h0000;
    step();
    chk_idle("t2_release");
    bus.req = 16'h0021;
    step();
    chk_gnt("t2_ptr6", 0);
    bus.req = 16'h8000;
    step();
    chk_idle("t3_pre_bubble");
    step();
    chk_gnt("t3_pre", 15);
    bus.req = 16'h0000;
    step();
    bus.req = 16'h8003;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_gnt("t3_order", exp_order[i]);
      step();
      chk_gnt("t3_hold", exp_order[i]);
      bus.req = 16'h8003 & ~(16'd1 << exp_order[i]);
      step();
      chk_idle("t3_bubble");
      bus.req = 16'h8003;
    end
    bus.req = 16'h0000;
    step();
    bus.req = 16'h0008;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_gnt("t4_held", 3);
      chk("t4_no_preempt", {31'd0, bus.preempt}, 32'd0);
    end
    step();
    chk_idle("t4_timeout");
    chk("t4_preempt", {31'd0, bus.preempt}, 32'd1);
    step();
    chk_gnt("t4_regrant", 3);
    chk("t4_pulse_end", {31'd0, bus.preempt}, 32'd0);
    repeat (4) step();
    chk("t4_preempt2", {31'd0, bus.preempt}, 32'd1);
    bus.req = 16'h0009;
    step();
    chk_gnt("t4_other_first", 0);
    bus.req = 16'h2000;
    step();
    step();
    chk_gnt("t5_idx13", 13);
    bus.req = 16'h0000;
    step();
    bus.req = 16'h4001;
    step();
    chk_gnt("t5_wrap14", 14);
    bus.req = 16'h0001;
    step();
    chk_idle("t5_bubble");
    bus.req = 16'h4001;
    step();
    chk_gnt("t5_then0", 0);
    bus.req = 16'h8000;
    step();
    step();
    chk_gnt("t6_pre", 15);
    bus.req = 16'h0000;
    step();
    bus.req = 16'h0080;
    step();
    chk_gnt("t6_grant7", 7);
    bus.en = 1'b0;
    step();
    chk_idle("t6_disable");
    chk("t6_no_preempt", {31'd0, bus.preempt}, 32'd0);
    bus.en = 1'b1;
    bus.req = 16'h0204;
    step();
    chk_gnt("t6_ptr_kept", 2);
    #3;
    rst = 1'b1;
    #1;
    chk_idle("t6_async_rst");
    chk("t6_rst_idx", {28'd0, bus.gnt_idx}, 32'd0);
    rst = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
